// File: rtl/rh_ahb5_arbiter.sv
// rh_ahb5_arbiter: round-robin AHB5 bus arbiter that hands over only at legal AHB points
// Ports: HCLK/HRESET clock and sync active-high reset; HBUSREQ/HLOCK per-manager request/lock;
//        HTRANS/HBURST/HREADY post-mux address-phase controls; HGRANT one-hot owner;
//        HMASTER/HMASTERD address/data-phase owner IDs; HMASTLOCK locked sequence.
// Optional lock support: define RH_AHB5_ARB_LOCK_EN.
module rh_ahb5_arbiter #(
   parameter int NM             = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic [NM-1:0] HBUSREQ,
   input  logic [NM-1:0] HLOCK,
   input  logic [1:0]    HTRANS,
   input  logic [2:0]    HBURST,
   input  logic          HREADY,
   output logic [NM-1:0] HGRANT,
   output logic [3:0]    HMASTER,
   output logic [3:0]    HMASTERD,
   output logic          HMASTLOCK
);
   localparam int IW = $clog2(NM);
   localparam logic [IW-1:0] DM = IW'(DEFAULT_MASTER);
   typedef enum logic [1:0] {S_OPEN, S_BURST, S_LOCKED} state_t;
   state_t        r_state, w_state_n;
   logic [IW-1:0] r_owner, w_owner_n, w_rr, w_sel, w_idx;
   logic [3:0]    r_masterd;
   logic [4:0]    r_cnt, w_cnt_n, w_len;
   logic          w_accept, w_free, w_keep;
   logic [NM-1:0] w_lock;
`ifdef RH_AHB5_ARB_LOCK_EN
   assign w_lock = HLOCK;
`else
   logic w_unused;
   assign w_lock   = '0;
   assign w_unused = ^HLOCK;
`endif
   assign w_accept = HREADY & HTRANS[1];
   assign w_len    = HBURST[2:1] == 2'd0 ? 5'd0 : HBURST[2:1] == 2'd1 ? 5'd3 :
                     HBURST[2:1] == 2'd2 ? 5'd7 : 5'd15;
   assign w_cnt_n  = !w_accept ? r_cnt : !HTRANS[0] ? w_len : r_cnt - 5'(r_cnt != 5'd0);
   // a zero count after this cycle is a legal handover: idle/open cycles and the last burst beat
   assign w_free   = w_cnt_n == 5'd0;
   assign w_keep   = HBUSREQ[r_owner] & (HBURST == 3'b001) & HTRANS[0];
   // the owner doubles as the round-robin pointer: the pointer always follows the owner
   always_comb begin
      w_rr  = DM;
      w_idx = '0;
      for (int i = NM; i >= 1; i--) begin
         w_idx = IW'((int'(r_owner) + i) % NM);
         if (HBUSREQ[w_idx]) w_rr = w_idx;
      end
   end
   assign w_sel = (w_lock[r_owner] | w_keep) ? r_owner : w_rr;
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state   <= S_OPEN;
         r_owner   <= DM;
         r_cnt     <= 5'd0;
         r_masterd <= 4'(DM);
      end else if (HREADY) begin
         r_state   <= w_state_n;
         r_owner   <= w_owner_n;
         r_cnt     <= w_cnt_n;
         r_masterd <= HMASTER;
      end
   end
   always_comb begin
      w_owner_n = w_free ? w_sel : r_owner;
      w_state_n = w_free ? (w_lock[w_sel] ? S_LOCKED : S_OPEN) :
                  (r_state == S_LOCKED ? S_LOCKED : S_BURST);
   end
   always_comb begin
      HGRANT    = {{(NM-1){1'b0}}, 1'b1} << r_owner;
      HMASTER   = 4'(r_owner);
      HMASTERD  = r_masterd;
      HMASTLOCK = r_state == S_LOCKED;
   end
endmodule

// File: tb/tb_rh_ahb5_arbiter.sv
// tb_rh_ahb5_arbiter: directed plus randomized check of rh_ahb5_arbiter against a transfer-level model
module tb_rh_ahb5_arbiter;
   localparam int NM = 4;
   localparam int DM = 0;
`ifdef RH_AHB5_ARB_LOCK_EN
   localparam bit LK = 1'b1;
`else
   localparam bit LK = 1'b0;
`endif
   localparam logic [1:0] ID = 2'b00, BY = 2'b01, NS = 2'b10, SQ = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011, INCR8 = 3'b101;
   logic          HCLK = 1'b0, HRESET = 1'b1, HREADY = 1'b1;
   logic [NM-1:0] HBUSREQ = '0, HLOCK = '0, HGRANT;
   logic [1:0]    HTRANS = ID;
   logic [2:0]    HBURST = SINGLE;
   logic [3:0]    HMASTER, HMASTERD;
   logic          HMASTLOCK;
   int checks = 0, errors = 0;
   int m_owner = DM, m_rem = 0, m_md = DM;
   bit m_lock = 1'b0;
   rh_ahb5_arbiter #(.NM(NM), .DEFAULT_MASTER(DM)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
      .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
      .HMASTERD(HMASTERD), .HMASTLOCK(HMASTLOCK));
   always #5 HCLK = ~HCLK;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic int next_rr(input logic [NM-1:0] req, input int p);
      for (int k = 1; k <= NM; k++) if (req[(p + k) % NM]) return (p + k) % NM;
      return DM;
   endfunction
   task automatic step(input logic [NM-1:0] req, input logic [NM-1:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic rst);
      int rem_n, nw;
      HBUSREQ = req; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESET = rst;
      @(posedge HCLK);
      if (rst) begin
         m_owner = DM; m_rem = 0; m_md = DM; m_lock = 1'b0;
      end else if (rdy) begin
         rem_n = m_rem;
         if (tr == NS) rem_n = (bu[2:1] == 2'd0) ? 0 : (4 << (int'(bu[2:1]) - 1)) - 1;
         else if (tr == SQ) rem_n = (m_rem > 0) ? m_rem - 1 : 0;
         m_md = m_owner;
         if (rem_n == 0) begin
            if (LK && lk[m_owner]) m_lock = 1'b1;
            else begin
               nw = (req[m_owner] && bu == INCR && tr[0]) ? m_owner : next_rr(req, m_owner);
               m_owner = nw;
               m_lock = LK && lk[nw];
            end
         end
         m_rem = rem_n;
      end
      #1;
      chk("grant", 32'(HGRANT), 32'(1) << m_owner);
      chk("hmaster", 32'(HMASTER), 32'(m_owner));
      chk("hmasterd", 32'(HMASTERD), 32'(m_md));
      chk("mastlock", 32'(HMASTLOCK), 32'(m_lock));
   endtask
   initial begin
      int rr_exp[5] = '{1, 2, 3, 0, 1};
      logic [NM-1:0] lk;
      step('0, '0, ID, SINGLE, 1'b1, 1'b1);
      step('0, '0, ID, SINGLE, 1'b1, 1'b1);
      chk("reset_grant", 32'(HGRANT), 32'h1);
      chk("reset_hmaster", 32'(HMASTER), 0);
      chk("reset_hmasterd", 32'(HMASTERD), 0);
      chk("reset_lock", 32'(HMASTLOCK), 0);
      for (int i = 0; i < 5; i++) begin
         step(4'hF, '0, NS, SINGLE, 1'b1, 1'b0);
         chk("rr_owner", 32'(HMASTER), 32'(rr_exp[i]));
         chk("rr_dphase", 32'(HMASTERD), 32'(i == 0 ? 0 : rr_exp[i-1]));
      end
      step('0, '0, ID, SINGLE, 1'b1, 1'b1);
      step(4'b0010, '0, ID, SINGLE, 1'b1, 1'b0);
      step(4'b0110, '0, NS, INCR4, 1'b1, 1'b0);
      chk("burst_beat1", 32'(HMASTER), 1);
      step(4'b0110, '0, SQ, INCR4, 1'b1, 1'b0);
      step(4'b0110, '0, SQ, INCR4, 1'b1, 1'b0);
      chk("burst_beat3", 32'(HMASTER), 1);
      step(4'b0110, '0, SQ, INCR4, 1'b1, 1'b0);
      chk("burst_handover", 32'(HMASTER), 2);
      step('0, '0, ID, SINGLE, 1'b1, 1'b1);
      step(4'b0010, '0, ID, SINGLE, 1'b1, 1'b0);
      step(4'b0110, '0, NS, INCR4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(4'b0110, '0, SQ, INCR4, 1'b0, 1'b0);
         chk("stall_frozen", 32'(HMASTER), 1);
      end
      step(4'b0110, '0, SQ, INCR4, 1'b1, 1'b0);
      step(4'b0110, '0, BY, INCR4, 1'b1, 1'b0);
      chk("busy_frozen", 32'(HMASTER), 1);
      step(4'b0110, '0, SQ, INCR4, 1'b1, 1'b0);
      chk("stall_beat3", 32'(HMASTER), 1);
      step(4'b0110, '0, SQ, INCR4, 1'b1, 1'b0);
      chk("stall_handover", 32'(HMASTER), 2);
      step('0, '0, ID, SINGLE, 1'b1, 1'b0);
      chk("park", 32'(HMASTER), 32'(DM));
      step(4'b0010, '0, ID, SINGLE, 1'b1, 1'b0);
      step(4'b0010, '0, NS, INCR8, 1'b1, 1'b0);
      step(4'b0010, '0, SQ, INCR8, 1'b1, 1'b0);
      step(4'b0100, '0, SQ, INCR8, 1'b1, 1'b1);
      chk("midrst_grant", 32'(HGRANT), 32'h1);
      chk("midrst_hmasterd", 32'(HMASTERD), 0);
      step(4'b0100, '0, ID, SINGLE, 1'b1, 1'b0);
      chk("midrst_cnt_zero", 32'(HMASTER), 2);
`ifdef RH_AHB5_ARB_LOCK_EN
      step('0, '0, ID, SINGLE, 1'b1, 1'b1);
      step(4'hF, 4'b0100, NS, SINGLE, 1'b1, 1'b0);
      step(4'hF, 4'b0100, NS, SINGLE, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(4'hF, 4'b0100, NS, SINGLE, 1'b1, 1'b0);
         chk("lock_owner", 32'(HMASTER), 2);
         chk("lock_flag", 32'(HMASTLOCK), 1);
      end
      step(4'hF, '0, NS, SINGLE, 1'b1, 1'b0);
      chk("unlock_owner", 32'(HMASTER), 3);
      chk("unlock_flag", 32'(HMASTLOCK), 0);
`endif
      for (int i = 0; i < 3000; i++) begin
         lk = ($urandom % 6 == 0) ? NM'($urandom) : '0;
         step(NM'($urandom), lk, 2'($urandom), 3'($urandom), 1'($urandom % 5 != 0),
              1'($urandom % 200 == 0));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
